// File: rtl/dpram_fifo_ctrl_pkg.sv
// dpram_fifo_ctrl_pkg: shared defaults and depth helper for the dual-port RAM FIFO controller.
package dpram_fifo_ctrl_pkg;
   localparam int DEF_DATA_W    = 12;
   localparam int DEF_ADDR_W    = 3;
   localparam int DEF_AFULL_TH  = 6;
   localparam int DEF_AEMPTY_TH = 2;
   function automatic int depth_of(input int addr_w);
      return 1 << addr_w;
   endfunction
endpackage

// File: rtl/dpram_fifo_ctrl.sv
// dpram_fifo_ctrl: FIFO controller driving a single-clock true dual-port RAM (port A write, port B read).
// Optional high-water-mark output enabled by defining DPRAM_FIFO_HWM_EN.
module dpram_fifo_ctrl
   import dpram_fifo_ctrl_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int AFULL_TH  = DEF_AFULL_TH,
   parameter int AEMPTY_TH = DEF_AEMPTY_TH
) (
   input  logic              clk,
   input  logic              reset_L,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [DATA_W-1:0] pop_data,
   output logic              pop_valid,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic              almost_empty,
   output logic [ADDR_W:0]   fifo_count,
   output logic              overflow_err,
   output logic              underflow_err,
   output logic [DATA_W-1:0] ram_data_a,
   output logic [ADDR_W-1:0] ram_addr_a,
   output logic              ram_we_a,
   output logic [DATA_W-1:0] ram_data_b,
   output logic [ADDR_W-1:0] ram_addr_b,
   output logic              ram_we_b,
   input  logic [DATA_W-1:0] ram_q_b
`ifdef DPRAM_FIFO_HWM_EN
   ,
   output logic [ADDR_W:0]   hwm
`endif
);
   localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W+1)'(depth_of(ADDR_W));
   localparam logic [ADDR_W:0] AFULL_C  = (ADDR_W+1)'(AFULL_TH);
   localparam logic [ADDR_W:0] AEMPTY_C = (ADDR_W+1)'(AEMPTY_TH);
   localparam logic [ADDR_W:0] ONE_C    = (ADDR_W+1)'(1);
   logic [ADDR_W-1:0] r_wr_ptr, r_rd_ptr;
   logic [ADDR_W:0]   r_count, w_count_nxt;
   logic              r_pop_valid, r_ovf, r_unf;
   logic              w_push_acc, w_pop_acc;
   assign full         = r_count == DEPTH_C;
   assign empty        = r_count == '0;
   assign almost_full  = r_count >= AFULL_C;
   assign almost_empty = r_count <= AEMPTY_C;
   assign fifo_count   = r_count;
   assign w_push_acc   = push & ~full;
   assign w_pop_acc    = pop & ~empty;
   assign w_count_nxt  = (w_push_acc & ~w_pop_acc) ? r_count + ONE_C :
                         (w_pop_acc & ~w_push_acc) ? r_count - ONE_C : r_count;
   assign ram_data_a    = push_data;
   assign ram_addr_a    = r_wr_ptr;
   assign ram_we_a      = w_push_acc;
   assign ram_data_b    = '0;
   assign ram_addr_b    = r_rd_ptr;
   assign ram_we_b      = 1'b0;
   assign pop_data      = ram_q_b;
   assign pop_valid     = r_pop_valid;
   assign overflow_err  = r_ovf;
   assign underflow_err = r_unf;
   // Pointers wrap naturally at ADDR_W bits; RAM contents survive reset.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_pop_valid <= 1'b0;
         r_ovf       <= 1'b0;
         r_unf       <= 1'b0;
      end else begin
         r_wr_ptr    <= w_push_acc ? r_wr_ptr + 1'b1 : r_wr_ptr;
         r_rd_ptr    <= w_pop_acc ? r_rd_ptr + 1'b1 : r_rd_ptr;
         r_count     <= w_count_nxt;
         r_pop_valid <= w_pop_acc;
         r_ovf       <= push & full;
         r_unf       <= pop & empty;
      end
   end
`ifdef DPRAM_FIFO_HWM_EN
   logic [ADDR_W:0] r_hwm;
   assign hwm = r_hwm;
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L)
         r_hwm <= '0;
      else if (w_count_nxt > r_hwm)
         r_hwm <= w_count_nxt;
   end
`endif
endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// tb_dpram_fifo_ctrl: randomized self-checking bench against a queue-based FIFO model with a behavioural RAM.
module tb_dpram_fifo_ctrl;
   logic        clk = 1'b0;
   logic        reset_L = 1'b0;
   logic        push = 1'b0, pop = 1'b0;
   logic [11:0] push_data = '0;
   logic [11:0] pop_data, ram_data_a, ram_data_b;
   logic [11:0] ram_q_b = '0;
   logic [2:0]  ram_addr_a, ram_addr_b;
   logic        ram_we_a, ram_we_b;
   logic        pop_valid, full, empty, almost_full, almost_empty, overflow_err, underflow_err;
   logic [3:0]  fifo_count;
`ifdef DPRAM_FIFO_HWM_EN
   logic [3:0]  hwm;
`endif
   logic [11:0] mem [8];
   logic [11:0] q [$];
   int          n_chk = 0, n_fail = 0, peak = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_we_a) mem[ram_addr_a] <= ram_data_a;
      ram_q_b <= mem[ram_addr_b];
   end

   dpram_fifo_ctrl dut (
      .clk(clk), .reset_L(reset_L), .push(push), .push_data(push_data), .pop(pop),
      .pop_data(pop_data), .pop_valid(pop_valid), .full(full), .empty(empty),
      .almost_full(almost_full), .almost_empty(almost_empty), .fifo_count(fifo_count),
      .overflow_err(overflow_err), .underflow_err(underflow_err),
      .ram_data_a(ram_data_a), .ram_addr_a(ram_addr_a), .ram_we_a(ram_we_a),
      .ram_data_b(ram_data_b), .ram_addr_b(ram_addr_b), .ram_we_b(ram_we_b),
      .ram_q_b(ram_q_b)
`ifdef DPRAM_FIFO_HWM_EN
      , .hwm(hwm)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic chk_flags(input string ph);
      int n;
      n = q.size();
      chk({ph, " count"}, 32'(fifo_count), 32'(n));
      chk({ph, " empty"}, 32'(empty), 32'(n == 0));
      chk({ph, " full"}, 32'(full), 32'(n == 8));
      chk({ph, " afull"}, 32'(almost_full), 32'(n >= 6));
      chk({ph, " aempty"}, 32'(almost_empty), 32'(n <= 2));
   endtask

   task automatic step(input logic p, input logic [11:0] d, input logic r);
      int n;
      logic pacc, racc;
      logic [11:0] w;
      @(negedge clk);
      push = p; push_data = d; pop = r;
      #1;
      n = q.size();
      pacc = p && n < 8;
      racc = r && n > 0;
      chk_flags("pre");
      chk("we_a", 32'(ram_we_a), 32'(pacc));
      chk("we_b", 32'(ram_we_b), 32'd0);
      chk("data_b", 32'(ram_data_b), 32'd0);
      @(posedge clk);
      w = '0;
      if (racc) w = q.pop_front();
      if (pacc) q.push_back(d);
      if (q.size() > peak) peak = q.size();
      #1;
      chk("pop_valid", 32'(pop_valid), 32'(racc));
      if (racc) chk("pop_data", 32'(pop_data), 32'(w));
      chk("overflow", 32'(overflow_err), 32'(p && n == 8));
      chk("underflow", 32'(underflow_err), 32'(r && n == 0));
`ifdef DPRAM_FIFO_HWM_EN
      chk("hwm", 32'(hwm), 32'(peak));
`endif
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk_flags("reset");
      chk("reset pop_valid", 32'(pop_valid), 32'd0);
      @(negedge clk) reset_L = 1'b1;
      repeat (2) step(1'b0, 12'h0, 1'b0);
      for (int i = 0; i < 8; i++) step(1'b1, 12'h0A1 + 12'(i), 1'b0);
      step(1'b1, 12'hFFF, 1'b0);
      step(1'b0, 12'h0, 1'b0);
`ifdef DPRAM_FIFO_HWM_EN
      chk("hwm after fill", 32'(hwm), 32'd8);
`endif
      for (int i = 0; i < 8; i++) step(1'b0, 12'h0, 1'b1);
      step(1'b0, 12'h0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b1, 12'($urandom), 1'b0);
      for (int i = 0; i < 20; i++) step(1'b1, 12'($urandom), 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, 12'h0, 1'b1);
      step(1'b1, 12'h123, 1'b1);
      step(1'b0, 12'h0, 1'b1);
      for (int i = 0; i < 300; i++) step(1'($urandom), 12'($urandom), 1'($urandom));
      while (q.size() > 0) step(1'b0, 12'h0, 1'b1);
      for (int i = 0; i < 6; i++) step(1'b1, 12'h300 + 12'(i), 1'b0);
      step(1'b0, 12'h0, 1'b1);
      chk("pre-reset pop_valid", 32'(pop_valid), 32'd1);
      #2 reset_L = 1'b0;
      push = 1'b0; pop = 1'b0;
      q.delete();
      peak = 0;
      #1;
      chk_flags("async reset");
      chk("async reset pop_valid", 32'(pop_valid), 32'd0);
      chk("async reset ovf", 32'(overflow_err), 32'd0);
      chk("async reset unf", 32'(underflow_err), 32'd0);
`ifdef DPRAM_FIFO_HWM_EN
      chk("async reset hwm", 32'(hwm), 32'd0);
`endif
      @(negedge clk) reset_L = 1'b1;
      step(1'b1, 12'h456, 1'b0);
      step(1'b0, 12'h0, 1'b1);
      step(1'b0, 12'h0, 1'b0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
